// File: rtl/data_bus_responder.sv
// Single-port word SRAM slave for the core data bus with configurable wait states.
module data_bus_responder #(
    parameter int unsigned MEM_WORDS   = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_mem_rd_i,
    input  logic        data_mem_wr_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_write_i,
    output logic        data_mem_rsp_o,
    output logic [31:0] data_read_o,
    output logic        data_err_o
);

    localparam int unsigned AW       = $clog2(MEM_WORDS);
    localparam logic [3:0]  WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          kind_q, kind_d;   // 1 = write
    logic          inr_q, inr_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rsp_q, rsp_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [31:0]   mem [MEM_WORDS];

    // BASE_ADDR is aligned to the array size, so word-granular subtraction suffices.
    logic [29:0] word_off;
    logic        addr_in_range;
    logic        unused_addr_bits;

    assign word_off         = data_addr_i[31:2] - BASE_ADDR[31:2];
    assign addr_in_range    = (word_off[29:AW] == '0);
    assign unused_addr_bits = ^data_addr_i[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        inr_d   = inr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rsp_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (data_mem_rd_i || data_mem_wr_i) begin
                    kind_d  = data_mem_wr_i;
                    inr_d   = addr_in_range;
                    idx_d   = word_off[AW-1:0];
                    wdata_d = data_write_i;
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered so they become valid on the same edge that enters StResp.
        if (state_d == StResp && state_q != StResp) begin
            rsp_d = 1'b1;
            err_d = !inr_d;
            if (!kind_d) begin
                rdata_d = inr_d ? mem[idx_d] : 32'h0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            kind_q  <= 1'b0;
            inr_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0;
            rsp_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            inr_q   <= inr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rsp_q   <= rsp_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Commit happens on the edge leaving StResp; reset forces StIdle so aborted writes drop.
    always_ff @(posedge clk) begin
        if (state_q == StResp && kind_q && inr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

`ifdef DBR_INIT_EN
    initial begin
        if (INIT_FILE == "") begin
            $fatal(1, "data_bus_responder: DBR_INIT_EN set but INIT_FILE is empty");
        end
    end
`endif

    assign data_mem_rsp_o = rsp_q;
    assign data_err_o     = err_q;
    assign data_read_o    = rdata_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench: three responder instances with different wait states and base addresses.
module tb_data_bus_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        bus_rd    [3];
    logic        bus_wr    [3];
    logic [31:0] bus_addr  [3];
    logic [31:0] bus_wdata [3];
    logic        bus_rsp   [3];
    logic [31:0] bus_rdata [3];
    logic        bus_err   [3];

    int unsigned cfg_ws    [3] = '{0, 3, 5};
    int unsigned cfg_words [3] = '{1024, 1024, 256};
    logic [31:0] cfg_base  [3] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000};

    data_bus_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0),
                         .INIT_FILE("")) u_dut0 (
        .clk(clk), .rst(rst), .data_mem_rd_i(bus_rd[0]), .data_mem_wr_i(bus_wr[0]),
        .data_addr_i(bus_addr[0]), .data_write_i(bus_wdata[0]), .data_mem_rsp_o(bus_rsp[0]),
        .data_read_o(bus_rdata[0]), .data_err_o(bus_err[0]));

    data_bus_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(3),
                         .INIT_FILE("")) u_dut1 (
        .clk(clk), .rst(rst), .data_mem_rd_i(bus_rd[1]), .data_mem_wr_i(bus_wr[1]),
        .data_addr_i(bus_addr[1]), .data_write_i(bus_wdata[1]), .data_mem_rsp_o(bus_rsp[1]),
        .data_read_o(bus_rdata[1]), .data_err_o(bus_err[1]));

    data_bus_responder #(.MEM_WORDS(256), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(5),
                         .INIT_FILE("")) u_dut2 (
        .clk(clk), .rst(rst), .data_mem_rd_i(bus_rd[2]), .data_mem_wr_i(bus_wr[2]),
        .data_addr_i(bus_addr[2]), .data_write_i(bus_wdata[2]), .data_mem_rsp_o(bus_rsp[2]),
        .data_read_o(bus_rdata[2]), .data_err_o(bus_err[2]));

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } acc_t;

    exp_t        sb [$];
    logic [31:0] mdl [int];
    logic [31:0] last_rd [3] = '{32'h0, 32'h0, 32'h0};
    int          checks = 0;
    int          errors = 0;

    task automatic predict(input int i, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        logic [31:0] off;
        logic        inr;
        int          key;
        off     = a - cfg_base[i];
        inr     = off < cfg_words[i] * 4;
        key     = i * 1048576 + int'(off >> 2);
        e.lat   = int'(cfg_ws[i]) + 1;
        e.err   = !inr;
        if (w) begin
            if (inr) mdl[key] = d;
            e.rdata = last_rd[i];
        end else begin
            e.rdata    = (inr && r) ? mdl[key] : 32'h0;
            last_rd[i] = e.rdata;
        end
        sb.push_back(e);
    endtask

    task automatic drive(input int i, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_rd[i]    = r;
        bus_wr[i]    = w;
        bus_addr[i]  = a;
        bus_wdata[i] = d;
        @(posedge clk);
    endtask

    task automatic collect(input int i, input bit hold, output int lat, output logic err,
                           output logic [31:0] rdata, output logic single);
        lat    = -1;
        err    = 1'bx;
        rdata  = 'x;
        single = 1'b0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(negedge clk);
            if (bus_rsp[i]) begin
                lat   = n;
                err   = bus_err[i];
                rdata = bus_rdata[i];
            end
            if (n == 1 && !hold) begin
                bus_rd[i] = 1'b0;
                bus_wr[i] = 1'b0;
            end
        end
        if (lat > 0) begin
            @(negedge clk);
            single = !bus_rsp[i];
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus_rsp[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_rsp[%0d] got %b want 0", i, bus_rsp[i]);
            end
            checks++;
            if (bus_err[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_err[%0d] got %b want 0", i, bus_err[i]);
            end
            checks++;
            if (bus_rdata[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_rdata[%0d] got %h want 0", i, bus_rdata[i]);
            end
        end
        rst = 1'b0;
    endtask

    // Runs a list of accesses on one instance, checking each response against the scoreboard.
    task automatic test_sequence(input string name, input int i, input acc_t seq [$]);
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic        single;
        exp_t        e;
        foreach (seq[k]) begin
            predict(i, seq[k].r, seq[k].w, seq[k].a, seq[k].d);
            drive(i, seq[k].r, seq[k].w, seq[k].a, seq[k].d);
            collect(i, 1'b0, lat, err, rdata, single);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat) begin
                errors++;
                $display("FAIL %s[%0d] latency got %0d want %0d", name, k, lat, e.lat);
            end
            checks++;
            if (err !== e.err) begin
                errors++;
                $display("FAIL %s[%0d] err got %b want %b", name, k, err, e.err);
            end
            checks++;
            if (rdata !== e.rdata) begin
                errors++;
                $display("FAIL %s[%0d] rdata got %h want %h", name, k, rdata, e.rdata);
            end
            checks++;
            if (single !== 1'b1) begin
                errors++;
                $display("FAIL %s[%0d] rsp_single_cycle got %b want 1", name, k, single);
            end
        end
    endtask

    task automatic test_write_read;
        acc_t seq [$];
        seq.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF});
        seq.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h0});
        seq.push_back('{1'b0, 1'b1, 32'h0000_0014, 32'hCAFE_F00D});
        seq.push_back('{1'b1, 1'b0, 32'h0000_0017, 32'h0});
        seq.push_back('{1'b0, 1'b1, 32'h0000_0FFE, 32'h0F0F_A5A5});
        seq.push_back('{1'b1, 1'b0, 32'h0000_0FFC, 32'h0});
        seq.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h0});
        test_sequence("wr_rd", 0, seq);
    endtask

    task automatic test_rd_wr_both;
        acc_t seq [$];
        seq.push_back('{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678});
        seq.push_back('{1'b1, 1'b0, 32'h0000_0020, 32'h0});
        test_sequence("rdwr", 0, seq);
    endtask

    task automatic test_wait_states;
        acc_t        seq [$];
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic        single;
        exp_t        e;
        bit          extra;
        seq.push_back('{1'b0, 1'b1, 32'h8000_0010, 32'h55AA_33CC});
        seq.push_back('{1'b1, 1'b0, 32'h8000_0010, 32'h0});
        test_sequence("wait", 1, seq);
        // Read held high through RESP: exactly one more access, re-accepted from IDLE.
        predict(1, 1'b1, 1'b0, 32'h8000_0010, 32'h0);
        predict(1, 1'b1, 1'b0, 32'h8000_0010, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h8000_0010, 32'h0);
        for (int k = 0; k < 2; k++) begin
            collect(1, (k == 0), lat, err, rdata, single);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat) begin
                errors++;
                $display("FAIL held[%0d] latency got %0d want %0d", k, lat, e.lat);
            end
            checks++;
            if (rdata !== e.rdata || err !== e.err) begin
                errors++;
                $display("FAIL held[%0d] rdata/err got %h/%b want %h/%b", k, rdata, err,
                         e.rdata, e.err);
            end
        end
        extra = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus_rsp[1]) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0) begin
            errors++;
            $display("FAIL held_extra_rsp got %b want 0", extra);
        end
    endtask

    task automatic test_out_of_range;
        acc_t seq [$];
        seq.push_back('{1'b0, 1'b1, 32'h8000_0000, 32'h0BAD_0001});
        seq.push_back('{1'b0, 1'b1, 32'h8000_0FFC, 32'h0BAD_0002});
        seq.push_back('{1'b1, 1'b0, 32'h8000_1000, 32'h0});
        seq.push_back('{1'b0, 1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF});
        seq.push_back('{1'b0, 1'b1, 32'h8000_1000, 32'hEEEE_EEEE});
        seq.push_back('{1'b1, 1'b0, 32'h8000_0000, 32'h0});
        seq.push_back('{1'b1, 1'b0, 32'h8000_0FFC, 32'h0});
        test_sequence("oor", 1, seq);
    endtask

    task automatic test_reset_mid;
        acc_t seq [$];
        bit   seen;
        seq.push_back('{1'b0, 1'b1, 32'h0000_0040, 32'h1111_1111});
        test_sequence("rst_pre", 2, seq);
        // Aborted write: never predicted, so the model keeps the old word.
        drive(2, 1'b0, 1'b1, 32'h0000_0040, 32'h2222_2222);
        @(negedge clk);
        bus_wr[2] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus_rsp[2] !== 1'b0 || bus_err[2] !== 1'b0 || bus_rdata[2] !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs got %b/%b/%h want 0/0/0", bus_rsp[2], bus_err[2],
                     bus_rdata[2]);
        end
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n == 2) rst = 1'b0;
            if (bus_rsp[2]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_rsp got %b want 0", seen);
        end
        for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
        seq.delete();
        seq.push_back('{1'b1, 1'b0, 32'h0000_0040, 32'h0});
        test_sequence("rst_post", 2, seq);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            bus_rd[i]    = 1'b0;
            bus_wr[i]    = 1'b0;
            bus_addr[i]  = 32'h0;
            bus_wdata[i] = 32'h0;
        end
        test_reset();
        test_write_read();
        test_rd_wr_both();
        test_wait_states();
        test_out_of_range();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
